// File: rtl/ahb_slv_mem_responder_if.sv
// AHB slave bus bundle for ahb_slv_mem_responder: master-side request
// signals, slave-side response signals, arbiter outputs and burst-checker count.
interface ahb_slv_mem_responder_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic [ADDR_W-1:0] haddr;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [DATA_W-1:0] hwdata;
   logic              hbusreq;
   logic              hlock;
   logic [DATA_W-1:0] hrdata;
   logic              hready;
   logic [1:0]        hresp;
   logic              hgrant;
   logic [3:0]        hmaster;
   logic [15:0]       burst_err_cnt;

   modport slave (
      input  haddr, htrans, hwrite, hsize, hburst, hwdata, hbusreq, hlock,
      output hrdata, hready, hresp, hgrant, hmaster, burst_err_cnt
   );

   modport master (
      output haddr, htrans, hwrite, hsize, hburst, hwdata, hbusreq, hlock,
      input  hrdata, hready, hresp, hgrant, hmaster, burst_err_cnt
   );
endinterface

// File: rtl/ahb_slv_mem_responder.sv
// AHB slave bench model: word memory with byte-lane writes and write->read
// forwarding, configurable wait states (none / fixed / LFSR), two-cycle ERROR
// response for an address window and oversize transfers, single-master grant.
// Optional burst address checker enabled by defining AHB_SLV_BURST_CHECK_EN;
// without it burst_err_cnt is tied to zero.
module ahb_slv_mem_responder #(
   parameter int          ADDR_W     = 32,
   parameter int          DATA_W     = 64,
   parameter int          MEM_DEPTH  = 256,
   parameter int          WAIT_MODE  = 0,
   parameter int          FIXED_WAIT = 2,
   parameter int          MAX_WAIT   = 3,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter logic [31:0] ERR_BASE   = 32'hF000_0000,
   parameter logic [31:0] ERR_SIZE   = 32'h1000
) (
   input  logic                     hclk,
   input  logic                     hreset,
   ahb_slv_mem_responder_if.slave   bus
);
   localparam int NBYTES  = DATA_W / 8;
   localparam int BYTE_AW = $clog2(NBYTES);
   localparam int IDX_W   = $clog2(MEM_DEPTH);
   localparam logic [ADDR_W:0] ERR_LO = (ADDR_W+1)'(ERR_BASE);
   localparam logic [ADDR_W:0] ERR_HI = ERR_LO + (ADDR_W+1)'(ERR_SIZE);
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2, S_DATA} state_t;

   state_t              r_state;
   logic                r_hready;
   logic [1:0]          r_hresp;
   logic [DATA_W-1:0]   r_hrdata;
   logic [15:0]         r_lfsr;
   logic [7:0]          r_wcnt;
   logic [IDX_W-1:0]    r_idx;
   logic [BYTE_AW-1:0]  r_addr_lo;
   logic [2:0]          r_size;
   logic                r_write;
   logic                r_err;
   logic                r_hgrant;
   logic [3:0]          r_hmaster;
   logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

   logic                w_accept;
   logic [IDX_W-1:0]    w_new_idx;
   logic                w_err;
   logic [7:0]          w_wait_load;
   logic                w_lfsr_fb;
   logic [NBYTES-1:0]   w_lane_en;
   logic [DATA_W-1:0]   w_cur_word;
   logic [DATA_W-1:0]   w_wr_word;
   logic                w_commit;
   logic                w_fwd_hit;
   logic                w_unused;

   assign w_accept  = r_hready && bus.htrans[1];
   assign w_new_idx = bus.haddr[BYTE_AW +: IDX_W];
   assign w_err     = ((ERR_SIZE != 32'd0) && ({1'b0, bus.haddr} >= ERR_LO) &&
                       ({1'b0, bus.haddr} < ERR_HI)) || (bus.hsize > 3'(BYTE_AW));
   assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_unused  = ^{bus.hlock, bus.hburst, bus.htrans[0]};

   // Wait count loaded on each accepted transfer.
   generate
      if (WAIT_MODE == 1) begin : g_wait_fixed
         assign w_wait_load = 8'(FIXED_WAIT);
      end else if (WAIT_MODE == 2) begin : g_wait_lfsr
         assign w_wait_load = 8'(32'(r_lfsr[7:0]) % (MAX_WAIT + 1));
      end else begin : g_wait_none
         assign w_wait_load = 8'd0;
      end
   endgenerate

   // Merge write data into the stored word, one byte lane at a time; a lane
   // is written when it falls in the naturally aligned hsize-byte block.
   assign w_cur_word = r_mem[r_idx];
   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_lane
         assign w_lane_en[gi] = ((BYTE_AW'(gi) >> r_size) == (r_addr_lo >> r_size));
         assign w_wr_word[gi*8 +: 8] = w_lane_en[gi] ? bus.hwdata[gi*8 +: 8]
                                                     : w_cur_word[gi*8 +: 8];
      end
   endgenerate

   // Write commits at the end of its data phase; a read accepted in that same
   // cycle to the same word takes the merged word instead of the stale one.
   assign w_commit  = (r_state == S_DATA) && r_write;
   assign w_fwd_hit = w_commit && (w_new_idx == r_idx);

   // Memory: cleared on reset, byte-merged write at the end of a DATA write.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
      end else if (w_commit) begin
         r_mem[r_idx] <= w_wr_word;
      end
   end

   // Transfer FSM with registered hready/hresp/hrdata and data-phase capture.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state   <= S_IDLE;
         r_hready  <= 1'b1;
         r_hresp   <= RESP_OKAY;
         r_hrdata  <= '0;
         r_lfsr    <= LFSR_SEED;
         r_wcnt    <= 8'd0;
         r_idx     <= '0;
         r_addr_lo <= '0;
         r_size    <= 3'd0;
         r_write   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
            r_idx     <= w_new_idx;
            r_addr_lo <= bus.haddr[BYTE_AW-1:0];
            r_size    <= bus.hsize;
            r_write   <= bus.hwrite;
            r_err     <= w_err;
         end
         case (r_state)
            S_WAIT: begin
               if (r_wcnt <= 8'd1) begin
                  if (r_err) begin
                     r_state  <= S_ERR1;
                     r_hready <= 1'b0;
                     r_hresp  <= RESP_ERROR;
                  end else begin
                     r_state  <= S_DATA;
                     r_hready <= 1'b1;
                     r_hresp  <= RESP_OKAY;
                     if (!r_write) r_hrdata <= r_mem[r_idx];
                  end
               end else begin
                  r_wcnt <= r_wcnt - 8'd1;
               end
            end
            S_ERR1: begin
               r_state  <= S_ERR2;
               r_hready <= 1'b1;
               r_hresp  <= RESP_ERROR;
            end
            default: begin
               if (w_accept) begin
                  if (w_wait_load != 8'd0) begin
                     r_state  <= S_WAIT;
                     r_wcnt   <= w_wait_load;
                     r_hready <= 1'b0;
                     r_hresp  <= RESP_OKAY;
                  end else if (w_err) begin
                     r_state  <= S_ERR1;
                     r_hready <= 1'b0;
                     r_hresp  <= RESP_ERROR;
                  end else begin
                     r_state  <= S_DATA;
                     r_hready <= 1'b1;
                     r_hresp  <= RESP_OKAY;
                     if (!bus.hwrite) r_hrdata <= w_fwd_hit ? w_wr_word : r_mem[w_new_idx];
                  end
               end else begin
                  r_state  <= S_IDLE;
                  r_hready <= 1'b1;
                  r_hresp  <= RESP_OKAY;
               end
            end
         endcase
      end
   end

   // Single-master arbiter: grant follows request, hmaster moves on hready.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_hgrant  <= 1'b0;
         r_hmaster <= 4'd0;
      end else begin
         r_hgrant <= bus.hbusreq;
         if (r_hready) r_hmaster <= r_hgrant ? 4'd1 : 4'd0;
      end
   end

   assign bus.hready  = r_hready;
   assign bus.hresp   = r_hresp;
   assign bus.hrdata  = r_hrdata;
   assign bus.hgrant  = r_hgrant;
   assign bus.hmaster = r_hmaster;

`ifdef AHB_SLV_BURST_CHECK_EN
   logic              r_bc_active;
   logic              r_bc_fixed;
   logic [4:0]        r_bc_left;
   logic [2:0]        r_bc_burst;
   logic [2:0]        r_bc_size;
   logic [ADDR_W-1:0] r_bc_exp;
   logic [15:0]       r_bc_cnt;
   logic              w_bc_early;
   logic              w_bc_viol;

   function automatic logic [4:0] f_beats(input logic [2:0] burst);
      case (burst[2:1])
         2'b01:   return 5'd4;
         2'b10:   return 5'd8;
         2'b11:   return 5'd16;
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] addr,
                                                input logic [2:0] size,
                                                input logic [2:0] burst);
      logic [ADDR_W-1:0] incr;
      logic [ADDR_W-1:0] wmask;
      incr  = ADDR_W'(1) << size;
      wmask = (ADDR_W'(f_beats(burst)) << size) - ADDR_W'(1);
      if (burst != 3'b000 && !burst[0]) return (addr & ~wmask) | ((addr + incr) & wmask);
      return addr + incr;
   endfunction

   assign w_bc_early = r_bc_active && r_bc_fixed && (r_bc_left != 5'd0);

   // Classify the address phase presented this cycle as a burst violation.
   always_comb begin
      w_bc_viol = 1'b0;
      if (r_hready) begin
         case (bus.htrans)
            2'b11:        w_bc_viol = !r_bc_active || (bus.haddr != r_bc_exp);
            2'b10, 2'b00: w_bc_viol = w_bc_early;
            default:      w_bc_viol = 1'b0;
         endcase
      end
   end

   // Track expected next address/beats; count violations (saturating).
   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_bc_active <= 1'b0;
         r_bc_fixed  <= 1'b0;
         r_bc_left   <= 5'd0;
         r_bc_burst  <= 3'd0;
         r_bc_size   <= 3'd0;
         r_bc_exp    <= '0;
         r_bc_cnt    <= 16'd0;
      end else begin
         if (w_bc_viol) begin
            if (r_bc_cnt != 16'hFFFF) r_bc_cnt <= r_bc_cnt + 16'd1;
            $error("burst violation: htrans=%b haddr=%h", bus.htrans, bus.haddr);
         end
         if (r_hready) begin
            case (bus.htrans)
               2'b10: begin
                  r_bc_active <= (bus.hburst != 3'b000);
                  r_bc_fixed  <= (f_beats(bus.hburst) != 5'd0);
                  r_bc_left   <= (f_beats(bus.hburst) != 5'd0) ? f_beats(bus.hburst) - 5'd1 : 5'd0;
                  r_bc_burst  <= bus.hburst;
                  r_bc_size   <= bus.hsize;
                  r_bc_exp    <= f_next(bus.haddr, bus.hsize, bus.hburst);
               end
               2'b11: begin
                  if (r_bc_active) begin
                     r_bc_exp <= f_next(r_bc_exp, r_bc_size, r_bc_burst);
                     if (r_bc_fixed) begin
                        r_bc_left <= r_bc_left - 5'd1;
                        if (r_bc_left == 5'd1) r_bc_active <= 1'b0;
                     end
                  end
               end
               2'b00:   r_bc_active <= 1'b0;
               default: ;
            endcase
         end
      end
   end

   assign bus.burst_err_cnt = r_bc_cnt;
`else
   assign bus.burst_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ahb_slv_mem_responder.sv
// Directed bench for ahb_slv_mem_responder: dut0 runs without wait states,
// dut1 with two fixed wait states; htrans is steered to one DUT at a time.
module tb_ahb_slv_mem_responder;
   logic hclk = 1'b0;
   logic hreset = 1'b1;
   always #5 hclk = ~hclk;

   logic        sel;
   logic [31:0] t_haddr;
   logic [1:0]  t_htrans;
   logic        t_hwrite;
   logic [2:0]  t_hsize;
   logic [2:0]  t_hburst;
   logic [63:0] t_hwdata;
   logic        t_hbusreq;

   int n_pass = 0;
   int n_total = 0;

   ahb_slv_mem_responder_if #(.ADDR_W(32), .DATA_W(64)) bus0 ();
   ahb_slv_mem_responder_if #(.ADDR_W(32), .DATA_W(64)) bus1 ();

   assign bus0.haddr   = t_haddr;
   assign bus0.htrans  = sel ? 2'b00 : t_htrans;
   assign bus0.hwrite  = t_hwrite;
   assign bus0.hsize   = t_hsize;
   assign bus0.hburst  = t_hburst;
   assign bus0.hwdata  = t_hwdata;
   assign bus0.hbusreq = t_hbusreq;
   assign bus0.hlock   = 1'b0;
   assign bus1.haddr   = t_haddr;
   assign bus1.htrans  = sel ? t_htrans : 2'b00;
   assign bus1.hwrite  = t_hwrite;
   assign bus1.hsize   = t_hsize;
   assign bus1.hburst  = t_hburst;
   assign bus1.hwdata  = t_hwdata;
   assign bus1.hbusreq = 1'b0;
   assign bus1.hlock   = 1'b0;

   wire        w_hready = sel ? bus1.hready : bus0.hready;
   wire [1:0]  w_hresp  = sel ? bus1.hresp  : bus0.hresp;
   wire [63:0] w_hrdata = sel ? bus1.hrdata : bus0.hrdata;

   ahb_slv_mem_responder #(.WAIT_MODE(0)) dut0 (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus0.slave)
   );

   ahb_slv_mem_responder #(.WAIT_MODE(1), .FIXED_WAIT(2)) dut1 (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus1.slave)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [63:0] wd;
      logic [63:0] rd;
      logic [1:0]  resp;
      int          waits;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // One non-pipelined transfer; called just after a rising edge with hready=1.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [63:0] wd, output logic [63:0] rd,
                       output logic [1:0] resp, output int waits);
      t_haddr  = addr;
      t_hwrite = wr;
      t_hsize  = size;
      t_hburst = 3'b000;
      t_htrans = 2'b10;
      @(posedge hclk); #1;
      t_htrans = 2'b00;
      t_hwdata = wd;
      waits = 0;
      @(negedge hclk);
      while (!w_hready && waits < 20) begin
         waits++;
         @(negedge hclk);
      end
      rd   = w_hrdata;
      resp = w_hresp;
      @(posedge hclk); #1;
      $display("xfer dut%0d %s addr=%h size=%0d wdata=%h rdata=%h resp=%b waits=%0d",
               sel, wr ? "W" : "R", addr, size, wd, rd, resp, waits);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      logic [1:0]  resp;
      int          waits;
      logic [15:0] exp_bc;

      vecs[0]  = '{1'b1, 32'h0000_0010, 3'd3, 64'h1122_3344_5566_7788, 64'h0, 2'b00, 0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 3'd3, 64'h0, 64'h1122_3344_5566_7788, 2'b00, 0};
      vecs[2]  = '{1'b0, 32'hF000_0004, 3'd3, 64'h0, 64'h0, 2'b01, 1};
      vecs[3]  = '{1'b1, 32'hF000_0000, 3'd3, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 2'b01, 1};
      vecs[4]  = '{1'b0, 32'h0000_0000, 3'd3, 64'h0, 64'h0, 2'b00, 0};
      vecs[5]  = '{1'b0, 32'h0000_0010, 3'd4, 64'h0, 64'h0, 2'b01, 1};
      vecs[6]  = '{1'b1, 32'h0000_0810, 3'd3, 64'hCAFE_BABE_0102_0304, 64'h0, 2'b00, 0};
      vecs[7]  = '{1'b0, 32'h0000_0010, 3'd3, 64'h0, 64'hCAFE_BABE_0102_0304, 2'b00, 0};
      vecs[8]  = '{1'b1, 32'h0000_0014, 3'd1, 64'h1111_BEEF_2222_3333, 64'h0, 2'b00, 0};
      vecs[9]  = '{1'b0, 32'h0000_0010, 3'd3, 64'h0, 64'hCAFE_BEEF_0102_0304, 2'b00, 0};
      vecs[10] = '{1'b1, 32'h0000_0018, 3'd2, 64'hFFFF_FFFF_A5A5_A5A5, 64'h0, 2'b00, 0};
      vecs[11] = '{1'b0, 32'h0000_0018, 3'd3, 64'h0, 64'h0000_0000_A5A5_A5A5, 2'b00, 0};
      vecs[12] = '{1'b0, 32'hF000_0FF8, 3'd3, 64'h0, 64'h0, 2'b01, 1};
      vecs[13] = '{1'b0, 32'hF000_1000, 3'd3, 64'h0, 64'h0, 2'b00, 0};
      vecs[14] = '{1'b0, 32'hEFFF_FFF8, 3'd3, 64'h0, 64'h0, 2'b00, 0};

      sel = 1'b0; t_haddr = '0; t_htrans = 2'b00; t_hwrite = 1'b0; t_hsize = 3'd0;
      t_hburst = 3'd0; t_hwdata = '0; t_hbusreq = 1'b0;

      // Reset state
      repeat (3) @(posedge hclk);
      #1 hreset = 1'b0;
      check("rst_hready", 64'(bus0.hready), 64'd1);
      check("rst_hresp", 64'(bus0.hresp), 64'd0);
      check("rst_hrdata", bus0.hrdata, 64'd0);
      check("rst_hgrant", 64'(bus0.hgrant), 64'd0);
      check("rst_hmaster", 64'(bus0.hmaster), 64'd0);
      check("rst_burst_err_cnt", 64'(bus0.burst_err_cnt), 64'd0);

      // Table of single transfers on the zero-wait instance
      for (int i = 0; i < 15; i++) begin
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wd, rd, resp, waits);
         check($sformatf("v%0d_resp", i), 64'(resp), 64'(vecs[i].resp));
         check($sformatf("v%0d_waits", i), 64'(waits), 64'(vecs[i].waits));
         if (!vecs[i].wr && vecs[i].resp == 2'b00)
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
      end

      // Byte write to 0x13 immediately followed by a read of 0x10 (forwarding)
      t_haddr = 32'h13; t_hwrite = 1'b1; t_hsize = 3'd0; t_htrans = 2'b10;
      @(posedge hclk); #1;
      t_hwdata = 64'h5555_5555_AB66_6666;
      t_haddr = 32'h10; t_hwrite = 1'b0; t_hsize = 3'd3; t_htrans = 2'b10;
      @(posedge hclk); #1;
      t_htrans = 2'b00;
      check("fwd_hready", 64'(w_hready), 64'd1);
      check("fwd_hresp", 64'(w_hresp), 64'd0);
      check("fwd_hrdata", w_hrdata, 64'hCAFE_BEEF_AB02_0304);
      $display("xfer dut0 W+R fwd addr=13/10 rdata=%h", w_hrdata);
      @(posedge hclk); #1;
      xfer(1'b0, 32'h10, 3'd3, 64'h0, rd, resp, waits);
      check("fwd_mem_rdata", rd, 64'hCAFE_BEEF_AB02_0304);
      check("fwd_mem_waits", 64'(waits), 64'd0);

      // Fixed-wait instance
      sel = 1'b1;
      xfer(1'b0, 32'h8, 3'd3, 64'h0, rd, resp, waits);
      check("w1_rd_waits", 64'(waits), 64'd2);
      check("w1_rd_resp", 64'(resp), 64'd0);
      check("w1_rd_rdata", rd, 64'd0);
      xfer(1'b0, 32'hF000_0004, 3'd3, 64'h0, rd, resp, waits);
      check("w1_err_waits", 64'(waits), 64'd3);
      check("w1_err_resp", 64'(resp), 64'd1);
      xfer(1'b1, 32'h20, 3'd3, 64'h0123_4567_89AB_CDEF, rd, resp, waits);
      check("w1_wr_waits", 64'(waits), 64'd2);
      xfer(1'b0, 32'h20, 3'd3, 64'h0, rd, resp, waits);
      check("w1_rd2_rdata", rd, 64'h0123_4567_89AB_CDEF);
      check("w1_rd2_waits", 64'(waits), 64'd2);

      // Reset asserted mid-WAIT drops the pending write
      t_haddr = 32'h28; t_hwrite = 1'b1; t_hsize = 3'd3; t_htrans = 2'b10;
      @(posedge hclk); #1;
      t_htrans = 2'b00; t_hwdata = 64'h9999_9999_9999_9999;
      hreset = 1'b1;
      @(posedge hclk); #1;
      hreset = 1'b0;
      $display("xfer dut1 W addr=28 aborted by reset");
      check("rstw_hready", 64'(w_hready), 64'd1);
      check("rstw_hresp", 64'(w_hresp), 64'd0);
      xfer(1'b0, 32'h28, 3'd3, 64'h0, rd, resp, waits);
      check("rstw_rd28", rd, 64'd0);
      xfer(1'b0, 32'h20, 3'd3, 64'h0, rd, resp, waits);
      check("rstw_rd20", rd, 64'd0);
      sel = 1'b0;

      // Arbiter: grant follows hbusreq, hmaster follows grant on hready
      t_hbusreq = 1'b1;
      @(posedge hclk); #1;
      check("arb_grant_up", 64'(bus0.hgrant), 64'd1);
      check("arb_master_lag", 64'(bus0.hmaster), 64'd0);
      @(posedge hclk); #1;
      check("arb_master_up", 64'(bus0.hmaster), 64'd1);
      t_hbusreq = 1'b0;
      @(posedge hclk); #1;
      check("arb_grant_down", 64'(bus0.hgrant), 64'd0);
      check("arb_master_hold", 64'(bus0.hmaster), 64'd1);
      @(posedge hclk); #1;
      check("arb_master_down", 64'(bus0.hmaster), 64'd0);
      $display("xfer arbiter request up/down sequence done");

      // INCR4 with a bad third beat, then an INCR4 cut short by IDLE
      t_hwrite = 1'b0; t_hsize = 3'd3; t_hburst = 3'b011;
      t_htrans = 2'b10; t_haddr = 32'h00; @(posedge hclk); #1;
      t_htrans = 2'b11; t_haddr = 32'h08; @(posedge hclk); #1;
      t_htrans = 2'b11; t_haddr = 32'h20; @(posedge hclk); #1;
      t_htrans = 2'b11; t_haddr = 32'h18; @(posedge hclk); #1;
      t_htrans = 2'b00; @(posedge hclk); #1;
`ifdef AHB_SLV_BURST_CHECK_EN
      exp_bc = 16'd1;
`else
      exp_bc = 16'd0;
`endif
      check("burst_bad_beat", 64'(bus0.burst_err_cnt), 64'(exp_bc));
      t_htrans = 2'b10; t_haddr = 32'h40; @(posedge hclk); #1;
      t_htrans = 2'b11; t_haddr = 32'h48; @(posedge hclk); #1;
      t_htrans = 2'b00; @(posedge hclk); #1;
      @(posedge hclk); #1;
`ifdef AHB_SLV_BURST_CHECK_EN
      exp_bc = 16'd2;
`else
      exp_bc = 16'd0;
`endif
      check("burst_early_end", 64'(bus0.burst_err_cnt), 64'(exp_bc));
      $display("xfer burst sequences done, burst_err_cnt=%0d", bus0.burst_err_cnt);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
